// File: rtl/rx_filter_sequencer.sv
// rx_filter_sequencer
// Control sequencer for the time-multiplexed receive FIR datapath.
// It loads a coefficient set from a valid/ready stream into the coefficient
// BRAM. It then runs a TAPS-cycle frame schedule that produces one output
// sample per frame.
//
// Ports:
//   crx_clk, rrx_rst        clock / synchronous active-high reset
//   erx_en                  enable; low gates strobes and restarts the RUN frame
//   istart                  pulse: (re)start a coefficient load
//   icoeff_valid/_data      coefficient stream in; ocoeff_ready handshake
//   ocoeff_we/_wr_addr/_wr_data   coefficient BRAM write port (registered)
//   ocoeff_rd_addr          coefficient BRAM read address (frame counter)
//   osample_we/_wr_addr     sample history BRAM write port
//   osample_rd_addr         sample history BRAM read address
//   oacc_dump               accumulator dump strobe, once per frame
//   osample_ready           filtered output valid, one cycle after the dump
//   oload_done              pulse with the last coefficient write
//   ostate                  0 IDLE, 1 LOAD, 2 RUN
module rx_filter_sequencer #(
  parameter int unsigned TAPS = 512,
  parameter int unsigned AW   = 9
) (
  input  logic          crx_clk,
  input  logic          rrx_rst,
  input  logic          erx_en,
  input  logic          istart,
  input  logic          icoeff_valid,
  input  logic [15:0]   icoeff_data,
  output logic          ocoeff_ready,
  output logic          ocoeff_we,
  output logic [AW-1:0] ocoeff_wr_addr,
  output logic [15:0]   ocoeff_wr_data,
  output logic [AW-1:0] ocoeff_rd_addr,
  output logic          osample_we,
  output logic [AW-1:0] osample_wr_addr,
  output logic [AW-1:0] osample_rd_addr,
  output logic          oacc_dump,
  output logic          osample_ready,
  output logic          oload_done,
  output logic [1:0]    ostate
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;        // load counter
  logic [AW-1:0] c_q, c_d;        // frame counter
  logic [AW-1:0] wp_q, wp_d;      // sample write pointer
  logic [AW-1:0] srd_q, srd_d;    // sample read address
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic          coeff_ready;
  logic          beat;
  logic          frame_strobe;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    wp_d    = wp_q;
    srd_d   = srd_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;

    coeff_ready = (state_q == S_LOAD) && erx_en;
    beat        = coeff_ready && icoeff_valid;
    // A restart request suppresses the dump so a partial frame never emits.
    frame_strobe = (state_q == S_RUN) && erx_en && !istart && (c_q == '0);
    ready_d      = frame_strobe;

    if (!erx_en) begin
      if (state_q == S_RUN) begin
        c_d   = '0;
        wp_d  = '0;
        srd_d = AW'(1);
      end
    end else if (istart) begin
      state_d = S_LOAD;
      k_d     = '0;
      c_d     = '0;
      wp_d    = '0;
      srd_d   = AW'(1);
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (beat) begin
            we_d    = 1'b1;
            waddr_d = k_q;
            wdata_d = icoeff_data;
            k_d     = k_q + AW'(1);
            if (k_q == LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
              c_d     = '0;
              wp_d    = '0;
              srd_d   = AW'(1);
            end
          end
        end
        S_RUN: begin
          c_d = c_q + AW'(1);
          if (c_q == '0) begin
            wp_d = wp_q + AW'(1);
          end
          // Skip the slot being overwritten at the frame boundary.
          srd_d = srd_q + ((c_q == LAST) ? AW'(2) : AW'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= '0;
      wp_q    <= '0;
      srd_q   <= AW'(1);
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      wp_q    <= wp_d;
      srd_q   <= srd_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ocoeff_ready    = coeff_ready;
  assign ocoeff_we       = we_q;
  assign ocoeff_wr_addr  = waddr_q;
  assign ocoeff_wr_data  = wdata_q;
  assign ocoeff_rd_addr  = c_q;
  assign osample_we      = frame_strobe;
  assign osample_wr_addr = wp_q;
  assign osample_rd_addr = srd_q;
  assign oacc_dump       = frame_strobe;
  assign osample_ready   = ready_q;
  assign oload_done      = done_q;
  assign ostate          = state_q;

endmodule

// File: tb/tb_rx_filter_sequencer.sv
// Self-checking bench for rx_filter_sequencer (TAPS=8, AW=3).
// Directed phases plus a randomized phase. Every cycle's outputs are compared
// against a behavioural model. The model tracks the mode, the load index and
// the number of enabled RUN cycles since the frame sequence (re)started. The
// frame counter, write pointer and read address come from closed-form
// arithmetic on that count.
module tb_rx_filter_sequencer;
  localparam int T  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, en, start, valid;
  logic [15:0]   data;
  logic          coeff_ready, coeff_we, sample_we, acc_dump, sample_ready, load_done;
  logic [AW-1:0] coeff_wr_addr, coeff_rd_addr, sample_wr_addr, sample_rd_addr;
  logic [15:0]   coeff_wr_data;
  logic [1:0]    state;

  rx_filter_sequencer #(.TAPS(T), .AW(AW)) dut (
    .crx_clk(clk), .rrx_rst(rst), .erx_en(en), .istart(start),
    .icoeff_valid(valid), .icoeff_data(data),
    .ocoeff_ready(coeff_ready), .ocoeff_we(coeff_we),
    .ocoeff_wr_addr(coeff_wr_addr), .ocoeff_wr_data(coeff_wr_data),
    .ocoeff_rd_addr(coeff_rd_addr), .osample_we(sample_we),
    .osample_wr_addr(sample_wr_addr), .osample_rd_addr(sample_rd_addr),
    .oacc_dump(acc_dump), .osample_ready(sample_ready),
    .oload_done(load_done), .ostate(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // model state
  int          mst;    // 0 idle, 1 load, 2 run
  int          mk;
  int          rn;     // enabled RUN cycles since frame sequence start
  logic        p_we, p_done, p_ready;
  int          p_addr;
  logic [15:0] p_data;

  int writes_seen;
  int dumps_seen;
  int done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst = 0; mk = 0; rn = 0;
    p_we = 0; p_done = 0; p_ready = 0; p_addr = 0; p_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; valid = 1'b0; data = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: apply inputs, check all outputs mid-cycle, advance model.
  task automatic cycle(input logic st, input logic v, input logic e, input logic [15:0] d);
    logic exp_dump;
    logic n_ready, n_we, n_done;
    start = st; valid = v; en = e; data = d;
    #4;
    exp_dump = (mst == 2) && e && !st && (rn % T == 0);
    chk("ostate", 32'(state), 32'(mst));
    chk("ocoeff_ready", 32'(coeff_ready), 32'((mst == 1) && e));
    chk("ocoeff_we", 32'(coeff_we), 32'(p_we));
    chk("ocoeff_wr_addr", 32'(coeff_wr_addr), 32'(p_addr));
    chk("ocoeff_wr_data", 32'(coeff_wr_data), 32'(p_data));
    chk("oload_done", 32'(load_done), 32'(p_done));
    chk("oacc_dump", 32'(acc_dump), 32'(exp_dump));
    chk("osample_we", 32'(sample_we), 32'(exp_dump));
    chk("osample_ready", 32'(sample_ready), 32'(p_ready));
    chk("ocoeff_rd_addr", 32'(coeff_rd_addr), 32'(rn % T));
    chk("osample_wr_addr", 32'(sample_wr_addr), 32'(((rn + T - 1) / T) % T));
    chk("osample_rd_addr", 32'(sample_rd_addr), 32'((1 + rn + rn / T) % T));
    if (coeff_we === 1'b1) writes_seen++;
    if (acc_dump === 1'b1) dumps_seen++;
    if (load_done === 1'b1) done_seen++;

    n_ready = exp_dump; n_we = 1'b0; n_done = 1'b0;
    if (!e) begin
      if (mst == 2) rn = 0;
    end else if (st) begin
      mst = 1; mk = 0; rn = 0;
    end else if (mst == 1) begin
      if (v) begin
        n_we = 1'b1; p_addr = mk; p_data = d;
        if (mk == T - 1) begin mst = 2; n_done = 1'b1; rn = 0; end
        mk = (mk + 1) % T;
      end
    end else if (mst == 2) begin
      rn++;
    end
    p_we = n_we; p_done = n_done; p_ready = n_ready;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; valid = 1'b0; data = '0;
    @(posedge clk); #1;
    do_reset();

    // Idle after reset.
    repeat (20) cycle(1'b0, 1'b0, 1'b1, 16'h0);

    // Continuous load of 1..8, then RUN for 40 cycles.
    cycle(1'b1, 1'b0, 1'b1, 16'h0);
    writes_seen = 0; done_seen = 0;
    for (int i = 1; i <= T; i++) cycle(1'b0, 1'b1, 1'b1, 16'(i));
    dumps_seen = 0;
    repeat (40) cycle(1'b0, 1'b0, 1'b1, 16'h0);
    chk("load1_writes", 32'(writes_seen), 32'(T));
    chk("load1_done", 32'(done_seen), 32'd1);
    chk("run40_dumps", 32'(dumps_seen), 32'd5);

    // Disable for 3 cycles at c=5, then resume.
    while (rn % T != 5) cycle(1'b0, 1'b0, 1'b1, 16'h0);
    repeat (3) cycle(1'b0, $urandom_range(0, 1) == 1, 1'b0, 16'($urandom));
    repeat (20) cycle(1'b0, 1'b0, 1'b1, 16'h0);

    // Restart at c=3, then a load with valid toggling.
    while (rn % T != 3) cycle(1'b0, 1'b0, 1'b1, 16'h0);
    cycle(1'b1, 1'b0, 1'b1, 16'h0);
    writes_seen = 0; done_seen = 0;
    for (int i = 0; i < 2 * T; i++) cycle(1'b0, (i % 2) == 0, 1'b1, 16'($urandom));
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 16'h0);
    chk("load2_writes", 32'(writes_seen), 32'(T));
    chk("load2_done", 32'(done_seen), 32'd1);
    repeat (20) cycle(1'b0, 1'b0, 1'b1, 16'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) != 0, 16'($urandom));

    // Reset in the middle of a load at k=4: no further writes.
    cycle(1'b1, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 16'($urandom));
    do_reset();
    writes_seen = 0;
    repeat (10) cycle(1'b0, 1'b1, 1'b1, 16'($urandom));
    chk("post_reset_writes", 32'(writes_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rx_filter_sequencer.md
# rx_filter_sequencer

Control block for the time-multiplexed receive FIR datapath (coefficient BRAM, sample history BRAM, single MAC accumulator). It loads a new coefficient set through a valid/ready stream into the coefficient BRAM write port. It then runs the filter schedule: one output sample per TAPS-cycle frame, with coefficient read addresses, sample write/read addresses, and accumulator dump/ready strobes. It sits between the receive configuration path and the band-pass filter datapath and replaces the filter's free-running internal address counters.

## Interface
Parameters:
- TAPS, 512: cycles per output frame and number of coefficients; power of two, ≥ 4.
- AW, 9: address width; log2(TAPS).

Ports:
- crx_clk  in  1  clock; all logic on rising edge.
- rrx_rst  in  1  reset; synchronous, active-high.
- erx_en  in  1  enable; low gates all strobes and restarts the RUN frame.
- istart  in  1  one-cycle pulse; begin a coefficient load.
- icoeff_valid  in  1  coefficient beat valid.
- icoeff_data  in  16  signed coefficient.
- ocoeff_ready  out  1  coefficient beat accepted this cycle if valid.
- ocoeff_we  out  1  coefficient BRAM write enable.
- ocoeff_wr_addr  out  AW  coefficient BRAM write address.
- ocoeff_wr_data  out  16  coefficient BRAM write data.
- ocoeff_rd_addr  out  AW  coefficient BRAM read address.
- osample_we  out  1  sample BRAM write enable (new input sample).
- osample_wr_addr  out  AW  sample BRAM write address.
- osample_rd_addr  out  AW  sample BRAM read address.
- oacc_dump  out  1  datapath moves accumulator+current product to output register and clears accumulator.
- osample_ready  out  1  filtered output valid; one cycle after oacc_dump.
- oload_done  out  1  one-cycle pulse when the last coefficient is written.
- ostate  out  2  0 IDLE, 1 LOAD, 2 RUN.

## Operation
- States: IDLE, LOAD, RUN. Reset state is IDLE.
- Reset values:
  - All outputs are 0, except osample_rd_addr = 1.
  - Internal load counter k = 0; frame counter c = 0.
- IDLE:
  - Entry: istart & erx_en goes to LOAD and sets k = 0.
  - All strobes are 0.
- LOAD:
  - ocoeff_ready = erx_en; combinational from state and erx_en.
  - On each beat (icoeff_valid & ocoeff_ready), registered outputs on the next cycle:
    - ocoeff_we = 1, ocoeff_wr_addr = k, ocoeff_wr_data = icoeff_data.
    - k increments.
  - Beat k = TAPS-1 goes to RUN, with oload_done = 1 on the same registered cycle as the last write.
  - istart during LOAD restarts the load at k = 0.
- RUN:
  - c counts 0..TAPS-1 and wraps to 0.
  - ocoeff_rd_addr = c (registered copy).
  - When c = 0:
    - osample_we = 1 and oacc_dump = 1; osample_wr_addr is the current write pointer.
    - The write pointer increments (mod TAPS) after the write.
  - osample_rd_addr increments by 1 each cycle, by 2 on the cycle c = TAPS-1; mod 2^AW wrap. This skips the slot being written so the read stream stays aligned to the oldest-to-newest history.
  - istart in RUN goes to LOAD:
    - k = 0.
    - c, the write pointer and osample_rd_addr return to their reset values.
    - No dump is issued for the partial frame.
- erx_en low, in any state:
  - State is held; ocoeff_ready, ocoeff_we, osample_we, oacc_dump, osample_ready and oload_done are 0.
  - In RUN: c = 0, write pointer = 0, osample_rd_addr = 1.
  - In LOAD: k is held; the load resumes when erx_en returns.
- Precedence: rrx_rst > erx_en low > istart > normal sequencing.
- Arithmetic: all counters are unsigned AW bits with natural wrap; no saturation.

## Timing
- Entry to RUN: first RUN cycle has c = 0. The first dump occurs on the first RUN cycle whose c is 0, i.e. the first cycle in RUN with erx_en high. That frame's product is fresh-sample × coefficient only; the datapath discards the first output.
- Steady state: oacc_dump every TAPS cycles; osample_ready exactly 1 cycle later; period TAPS.
- Load throughput: one coefficient per cycle when valid is held high. LOAD lasts ≥ TAPS cycles; oload_done occurs TAPS cycles after the first accepted beat with valid continuous.
- istart pulse to ostate = 1: 1 cycle.
- Reset mid-LOAD or mid-RUN: the next cycle is IDLE with reset values, and the coefficient BRAM contents are untouched. A subsequent istart directly followed by a full load is required before RUN.

## Test plan
Bench uses TAPS=8, AW=3.
- Reset, then 20 idle cycles -> ostate=0, all strobes 0, osample_rd_addr=1.
- istart, then 8 continuous beats of data 0x0001..0x0008 -> ocoeff_we on 8 consecutive cycles at addresses 0..7 with the matching data. oload_done coincides with address 7; ostate=2 next cycle.
- Load with icoeff_valid toggling every other cycle -> exactly 8 writes at addresses 0..7; oload_done after 16 cycles.
- RUN for 40 cycles:
  - oacc_dump on cycles 0, 8, 16, 24, 32; osample_ready on 1, 9, ...
  - osample_wr_addr 0, 1, 2, ...
  - osample_rd_addr sequence 1, 2, …, 7, 0, then +2 skip at c=7 each frame.
- erx_en low for 3 cycles at c=5 -> strobes 0; after re-enable c restarts at 0 with an immediate dump; osample_rd_addr=1.
- istart at c=3 of RUN -> ostate=1 next cycle, no dump, counters reset. A further 8 beats returns to RUN. rrx_rst mid-LOAD at k=4 -> IDLE, no further writes.
